// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcode and branch funct3 encodings plus
// immediate-format helpers used by the decode stage.
package rv32_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BR2  = 3'b010;
  localparam logic [2:0] F3_BR3  = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
    imm_fmt_e f;
    f = IMM_NONE;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: f = IMM_I;
      OPC_STORE:                      f = IMM_S;
      OPC_BRANCH:                     f = IMM_B;
      OPC_LUI, OPC_AUIPC:             f = IMM_U;
      OPC_JAL:                        f = IMM_J;
      default:                        f = IMM_NONE;
    endcase
    return f;
  endfunction

  // Opcode field only; the low-bit and reserved-funct3 checks live in the stage.
  function automatic logic opc_legal(input logic [6:0] opc);
    logic ok;
    ok = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [XLEN-1:0] imm_gen(input logic [31:7] i, input imm_fmt_e f);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (f)
      IMM_I:   imm = {{21{i[31]}}, i[30:20]};
      IMM_S:   imm = {{21{i[31]}}, i[30:25], i[11:7]};
      IMM_B:   imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm = {i[31:12], 12'b0};
      IMM_J:   imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle between IF/ID, WB and the ID/EX register around the decode stage.
interface id_stage_if;
  import rv32_pkg::*;

  // No backpressure: pipe_data != 0 acts as the valid for IF/ID, wb_en is the
  // valid for writeback, ex_valid is the valid for ID/EX; every consumer is
  // always ready, so a beat transfers on each posedge where its valid is high.
  logic [XLEN-1:0] pipe_pc;
  logic [XLEN-1:0] pipe_pc4;
  logic [XLEN-1:0] pipe_data;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            control_j;
  logic [XLEN-1:0] pc_j;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_pc4;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5;
  logic            illegal_insn;
  logic            squash;

  modport master (
    output pipe_pc, pipe_pc4, pipe_data, wb_en, wb_rd, wb_data,
    input  control_j, pc_j, ex_valid, ex_pc, ex_pc4, ex_rs1_val, ex_rs2_val,
           ex_imm, ex_rd, ex_opcode, ex_funct3, ex_funct7b5, illegal_insn, squash
  );

  modport slave (
    input  pipe_pc, pipe_pc4, pipe_data, wb_en, wb_rd, wb_data,
    output control_j, pc_j, ex_valid, ex_pc, ex_pc4, ex_rs1_val, ex_rs2_val,
           ex_imm, ex_rd, ex_opcode, ex_funct3, ex_funct7b5, illegal_insn, squash
  );

endinterface

// File: rtl/regfile_2r1w.sv
// Integer register file: two combinational read ports with same-cycle
// writeback bypass, one posedge write port, x0 hardwired to zero.
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_live;

  assign wr_live = we && (waddr != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREGS; k++) begin
        regs[k] <= '0;
      end
    end else if (wr_live) begin
      regs[waddr] <= wdata;
    end
  end

  // Bypass lets an instruction in ID see the value WB commits this same edge.
  always_comb begin
    rdata1 = '0;
    if (raddr1 == '0) begin
      rdata1 = '0;
    end else if (wr_live && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 == '0) begin
      rdata2 = '0;
    end else if (wr_live && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs[raddr2];
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register read, immediate generation, early resolution
// of jumps/branches with a combinational redirect, and the ID/EX register.
module id_stage #(
  parameter int XLEN                      = 32,
  parameter int NREGS                     = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   reset_n,
  id_stage_if.slave bus
);
  import rv32_pkg::*;

  logic [XLEN-1:0] instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            squash;
  logic            live;
  logic            illegal;
  logic            is_jal;
  logic            is_jalr;
  logic            is_branch;
  logic            is_store;
  logic            taken;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd_dec;

  assign instr  = bus.pipe_data;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_store  = (opcode == OPC_STORE);

  // A word arriving right after a redirect is wrong-path and treated as a bubble.
  assign live = (instr != '0) && !squash;

  assign illegal = live && (!opc_legal(opcode) || (instr[1:0] != 2'b11) ||
                            (is_branch && ((funct3 == F3_BR2) || (funct3 == F3_BR3))));

  assign imm    = imm_gen(instr[31:7], imm_fmt(opcode));
  assign rd_dec = (is_store || is_branch) ? 5'd0 : rd;

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (bus.wb_en),
    .waddr  (bus.wb_rd),
    .wdata  (bus.wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_val == rs2_val);
      F3_BNE:  taken = (rs1_val != rs2_val);
      F3_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: taken = (rs1_val <  rs2_val);
      F3_BGEU: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    bus.control_j = 1'b0;
    bus.pc_j      = bus.pipe_pc4;
    if (live && !illegal) begin
      if (is_jal) begin
        bus.control_j = 1'b1;
        bus.pc_j      = bus.pipe_pc + imm;
      end else if (is_jalr) begin
        bus.control_j = 1'b1;
        bus.pc_j      = (rs1_val + imm) & {{(XLEN-1){1'b1}}, 1'b0};
      end else if (is_branch && taken) begin
        bus.control_j = 1'b1;
        bus.pc_j      = bus.pipe_pc + imm;
      end
    end
  end

  assign bus.squash = squash;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      squash           <= 1'b0;
      bus.illegal_insn <= 1'b0;
      bus.ex_valid     <= 1'b0;
      bus.ex_pc        <= '0;
      bus.ex_pc4       <= '0;
      bus.ex_rs1_val   <= '0;
      bus.ex_rs2_val   <= '0;
      bus.ex_imm       <= '0;
      bus.ex_rd        <= '0;
      bus.ex_opcode    <= '0;
      bus.ex_funct3    <= '0;
      bus.ex_funct7b5  <= 1'b0;
    end else begin
      squash           <= bus.control_j;
      bus.illegal_insn <= illegal;
      bus.ex_valid     <= live && !illegal;
      if (live) begin
        bus.ex_pc       <= bus.pipe_pc;
        bus.ex_pc4      <= bus.pipe_pc4;
        bus.ex_rs1_val  <= rs1_val;
        bus.ex_rs2_val  <= rs2_val;
        bus.ex_imm      <= imm;
        bus.ex_rd       <= rd_dec;
        bus.ex_opcode   <= opcode;
        bus.ex_funct3   <= funct3;
        bus.ex_funct7b5 <= instr[30];
      end else begin
        bus.ex_pc       <= RESET_VECTOR;
        bus.ex_pc4      <= '0;
        bus.ex_rs1_val  <= '0;
        bus.ex_rs2_val  <= '0;
        bus.ex_imm      <= '0;
        bus.ex_rd       <= '0;
        bus.ex_opcode   <= '0;
        bus.ex_funct3   <= '0;
        bus.ex_funct7b5 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized instruction streams
// checked against an instruction-level model of RV32I decode.
module tb_id_stage;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  id_stage_if bus ();

  id_stage dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b5;
    logic        ill;
  } ex_t;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [32];
  logic        m_squash = 1'b0;
  logic        cur_wen = 1'b0;
  logic [4:0]  cur_wrd = '0;
  logic [31:0] cur_wdata = '0;
  logic        exp_cj;
  logic [31:0] exp_pcj;
  ex_t         exp_e;
  ex_t         got;

  logic [6:0] opc_tab [11] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                              OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP,
                              OPC_MISC_MEM, OPC_SYSTEM};

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (cur_wen && cur_wrd == idx) return cur_wdata;
    return m_regs[idx];
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    logic [31:0] sgn;
    sgn = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    case (ins[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: return (sgn << 11) | (ins >> 20);
      OPC_STORE:  return (sgn << 11) | ((ins >> 25) << 5) | ((ins >> 7) & 32'h1F);
      OPC_BRANCH: return (sgn << 12) | (((ins >> 7) & 32'h1) << 11) |
                         (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
      OPC_LUI, OPC_AUIPC: return ins & 32'hFFFF_F000;
      OPC_JAL:    return (sgn << 20) | (ins & 32'h000F_F000) |
                         (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
      default:    return 32'h0;
    endcase
  endfunction

  function automatic void model_eval(input logic [31:0] ins, input logic [31:0] pc);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        live, known, ill, take;
    logic [31:0] a, b, imm;
    op    = ins[6:0];
    f3    = ins[14:12];
    live  = (ins != 32'h0) && !m_squash;
    known = op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                       OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM};
    ill   = live && (!known || ins[1:0] != 2'b11 ||
                     (op == OPC_BRANCH && (f3 == 3'd2 || f3 == 3'd3)));
    a     = m_read(ins[19:15]);
    b     = m_read(ins[24:20]);
    imm   = m_imm(ins);
    case (f3)
      3'd0:    take = (a == b);
      3'd1:    take = (a != b);
      3'd4:    take = ($signed(a) < $signed(b));
      3'd5:    take = !($signed(a) < $signed(b));
      3'd6:    take = (a < b);
      3'd7:    take = !(a < b);
      default: take = 1'b0;
    endcase
    exp_cj  = 1'b0;
    exp_pcj = pc + 32'd4;
    if (live && !ill) begin
      if (op == OPC_JAL) begin
        exp_cj = 1'b1; exp_pcj = pc + imm;
      end else if (op == OPC_JALR) begin
        exp_cj = 1'b1; exp_pcj = (a + imm) & 32'hFFFF_FFFE;
      end else if (op == OPC_BRANCH && take) begin
        exp_cj = 1'b1; exp_pcj = pc + imm;
      end
    end
    exp_e     = '0;
    exp_e.ill = ill;
    if (live) begin
      exp_e.valid = !ill;
      exp_e.pc    = pc;
      exp_e.pc4   = pc + 32'd4;
      exp_e.rs1   = a;
      exp_e.rs2   = b;
      exp_e.imm   = imm;
      exp_e.rd    = (op == OPC_STORE || op == OPC_BRANCH) ? 5'd0 : ins[11:7];
      exp_e.opc   = op;
      exp_e.f3    = f3;
      exp_e.f7b5  = ins[30];
    end
  endfunction

  function automatic void model_commit();
    if (cur_wen && cur_wrd != 5'd0) m_regs[cur_wrd] = cur_wdata;
    m_squash = exp_cj;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
    m_squash = 1'b0;
  endfunction

  function automatic ex_t got_ex();
    ex_t g;
    g.valid = bus.ex_valid;     g.pc   = bus.ex_pc;      g.pc4 = bus.ex_pc4;
    g.rs1   = bus.ex_rs1_val;   g.rs2  = bus.ex_rs2_val; g.imm = bus.ex_imm;
    g.rd    = bus.ex_rd;        g.opc  = bus.ex_opcode;  g.f3  = bus.ex_funct3;
    g.f7b5  = bus.ex_funct7b5;  g.ill  = bus.illegal_insn;
    return g;
  endfunction

  // ---------------- drivers ----------------
  task automatic apply(input logic [31:0] ins, input logic [31:0] pc, input logic wen,
                       input logic [4:0] wrd, input logic [31:0] wdata);
    bus.pipe_data = ins;
    bus.pipe_pc   = pc;
    bus.pipe_pc4  = pc + 32'd4;
    bus.wb_en     = wen;
    bus.wb_rd     = wrd;
    bus.wb_data   = wdata;
    cur_wen = wen; cur_wrd = wrd; cur_wdata = wdata;
    model_eval(ins, pc);
    #1;
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    apply(32'h0050_0093, 32'h40, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    got = got_ex();
    checks++;
    if (got !== '0 || bus.control_j !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: ex=%h cj=%b expected ex=0 cj=0", got, bus.control_j);
    end
    reset_n = 1'b1;
    advance();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd1 || bus.ex_imm !== 32'd5) begin
      errors++;
      $display("FAIL reset_release: valid=%b rd=%0d imm=%h expected 1 1 00000005",
               bus.ex_valid, bus.ex_rd, bus.ex_imm);
    end
    got = got_ex();
    checks++;
    if (got !== exp_e) begin
      errors++;
      $display("FAIL reset_release_model: got %h expected %h", got, exp_e);
    end
  endtask

  task automatic test_jal();
    apply(32'h0100_006F, 32'h100, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.control_j !== 1'b1 || bus.pc_j !== 32'h110) begin
      errors++;
      $display("FAIL jal_redirect: cj=%b pc_j=%h expected 1 00000110", bus.control_j, bus.pc_j);
    end
    advance();
    got = got_ex();
    checks++;
    if (got !== exp_e) begin
      errors++;
      $display("FAIL jal_ex: got %h expected %h", got, exp_e);
    end
    apply(32'h0010_0113, 32'h104, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.control_j !== 1'b0 || bus.pc_j !== 32'h108) begin
      errors++;
      $display("FAIL jal_squash_redirect: cj=%b pc_j=%h expected 0 00000108", bus.control_j, bus.pc_j);
    end
    advance();
    checks++;
    if (bus.ex_valid !== 1'b0 || got_ex() !== exp_e) begin
      errors++;
      $display("FAIL jal_squash_ex: valid=%b ex=%h expected valid=0 ex=%h", bus.ex_valid, got_ex(), exp_e);
    end
  endtask

  task automatic test_jalr();
    apply(32'h0, 32'h1F0, 1'b1, 5'd5, 32'h203);
    advance();
    apply(32'h0002_8067, 32'h200, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.control_j !== 1'b1 || bus.pc_j !== 32'h202) begin
      errors++;
      $display("FAIL jalr_align: cj=%b pc_j=%h expected 1 00000202", bus.control_j, bus.pc_j);
    end
    advance();
    apply(32'h0000_0013, 32'h204, 1'b0, 5'd0, 32'h0);
    advance();
    checks++;
    if (bus.ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL jalr_squash: valid=%b expected 0", bus.ex_valid);
    end
  endtask

  task automatic test_branch();
    apply(32'h0, 32'h2F0, 1'b1, 5'd1, 32'hFFFF_FFFF);
    advance();
    apply(32'h0, 32'h2F4, 1'b1, 5'd2, 32'h1);
    advance();
    apply(32'h0020_C463, 32'h300, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.control_j !== 1'b1 || bus.pc_j !== 32'h308) begin
      errors++;
      $display("FAIL blt_taken: cj=%b pc_j=%h expected 1 00000308", bus.control_j, bus.pc_j);
    end
    advance();
    checks++;
    if (bus.ex_rd !== 5'd0 || bus.ex_rs1_val !== 32'hFFFF_FFFF || bus.ex_rs2_val !== 32'h1 ||
        bus.ex_imm !== 32'h8 || bus.ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL blt_ex: rd=%0d rs1=%h rs2=%h imm=%h valid=%b expected 0 ffffffff 00000001 00000008 1",
               bus.ex_rd, bus.ex_rs1_val, bus.ex_rs2_val, bus.ex_imm, bus.ex_valid);
    end
    apply(32'h0, 32'h308, 1'b0, 5'd0, 32'h0);
    advance();
    apply(32'h0020_E463, 32'h310, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.control_j !== 1'b0 || bus.pc_j !== 32'h314) begin
      errors++;
      $display("FAIL bltu_not_taken: cj=%b pc_j=%h expected 0 00000314", bus.control_j, bus.pc_j);
    end
    advance();
    got = got_ex();
    checks++;
    if (got !== exp_e) begin
      errors++;
      $display("FAIL bltu_ex: got %h expected %h", got, exp_e);
    end
  endtask

  task automatic test_bypass();
    apply(32'h0001_8233, 32'h400, 1'b1, 5'd3, 32'hDEAD_BEEF);
    advance();
    checks++;
    if (bus.ex_rs1_val !== 32'hDEAD_BEEF || bus.ex_rd !== 5'd4) begin
      errors++;
      $display("FAIL bypass_rs1: rs1=%h rd=%0d expected deadbeef 4", bus.ex_rs1_val, bus.ex_rd);
    end
    apply(32'h0001_8233, 32'h404, 1'b0, 5'd0, 32'h0);
    advance();
    checks++;
    if (bus.ex_rs1_val !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL stored_x3: rs1=%h expected deadbeef", bus.ex_rs1_val);
    end
    apply(32'h0, 32'h408, 1'b1, 5'd0, 32'h1234);
    advance();
    apply(32'h0000_0333, 32'h40C, 1'b1, 5'd0, 32'h55);
    advance();
    checks++;
    if (bus.ex_rs1_val !== 32'h0 || bus.ex_rs2_val !== 32'h0 || bus.ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL x0_zero: rs1=%h rs2=%h valid=%b expected 0 0 1", bus.ex_rs1_val, bus.ex_rs2_val, bus.ex_valid);
    end
  endtask

  task automatic test_illegal();
    apply(32'hFFFF_FFFF, 32'h500, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.control_j !== 1'b0) begin
      errors++;
      $display("FAIL illegal_redirect: cj=%b expected 0", bus.control_j);
    end
    advance();
    checks++;
    if (bus.illegal_insn !== 1'b1 || bus.ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse: ill=%b valid=%b expected 1 0", bus.illegal_insn, bus.ex_valid);
    end
    apply(32'h0, 32'h504, 1'b0, 5'd0, 32'h0);
    advance();
    checks++;
    if (bus.illegal_insn !== 1'b0) begin
      errors++;
      $display("FAIL illegal_one_cycle: ill=%b expected 0", bus.illegal_insn);
    end
    // funct3=010 with x1 != x2 would be "taken" under BNE-like decoding
    apply(32'h0020_A463, 32'h508, 1'b0, 5'd0, 32'h0);
    checks++;
    if (bus.control_j !== 1'b0) begin
      errors++;
      $display("FAIL bad_branch_redirect: cj=%b expected 0", bus.control_j);
    end
    advance();
    checks++;
    if (bus.illegal_insn !== 1'b1 || bus.ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_branch_pulse: ill=%b valid=%b expected 1 0", bus.illegal_insn, bus.ex_valid);
    end
  endtask

  task automatic test_reset_mid();
    apply(32'h0, 32'h5F0, 1'b1, 5'd7, 32'hCAFE);
    advance();
    apply(32'h0050_0093, 32'h600, 1'b0, 5'd0, 32'h0);
    advance();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    got = got_ex();
    checks++;
    if (got !== '0 || bus.squash !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: ex=%h squash=%b expected 0 0", got, bus.squash);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    apply(32'h0003_8233, 32'h700, 1'b0, 5'd0, 32'h0);
    advance();
    checks++;
    if (bus.ex_rs1_val !== 32'h0 || bus.ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_rf_clear: rs1=%h valid=%b expected 0 1", bus.ex_rs1_val, bus.ex_valid);
    end
    apply(32'h0100_006F, 32'h100, 1'b0, 5'd0, 32'h0);
    advance();
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    model_reset();
    apply(32'h0050_0093, 32'h110, 1'b0, 5'd0, 32'h0);
    advance();
    checks++;
    if (bus.ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_clears_squash: valid=%b expected 1", bus.ex_valid);
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] ins, pc, r, wd;
    logic [4:0]  wrd;
    logic        wen;
    for (int it = 0; it < n; it++) begin
      r = $urandom_range(0, 15);
      ins = $urandom;
      if (r == 0) ins = 32'h0;
      else if (r > 1) begin
        ins[6:0] = opc_tab[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) == 1) begin
          ins[19:15] = 5'($urandom_range(0, 7));
          ins[24:20] = 5'($urandom_range(0, 7));
        end
      end
      pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
      wen = 1'($urandom_range(0, 1));
      wrd = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0:       wd = 32'h0;
        1:       wd = 32'h1;
        2:       wd = 32'hFFFF_FFFF;
        3:       wd = 32'h8000_0000;
        default: wd = $urandom;
      endcase
      apply(ins, pc, wen, wrd, wd);
      checks++;
      if (bus.control_j !== exp_cj || bus.pc_j !== exp_pcj) begin
        errors++;
        $display("FAIL rand_redirect: ins=%h cj=%b pc_j=%h expected cj=%b pc_j=%h",
                 ins, bus.control_j, bus.pc_j, exp_cj, exp_pcj);
      end
      advance();
      got = got_ex();
      checks++;
      if (exp_e.ill ? ({got.valid, got.ill} !== {exp_e.valid, exp_e.ill}) : (got !== exp_e)) begin
        errors++;
        $display("FAIL rand_ex: ins=%h got %h expected %h", ins, got, exp_e);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation bound expired");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    bus.pipe_data = '0; bus.pipe_pc = '0; bus.pipe_pc4 = 32'd4;
    bus.wb_en = 1'b0;   bus.wb_rd = '0;   bus.wb_data = '0;
    @(posedge clk); #1;
    test_reset();
    test_jal();
    test_jalr();
    test_branch();
    test_bypass();
    test_illegal();
    test_reset_mid();
    test_random(600);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
